// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and the sync/blanking decode shared by the
// sync generator and downstream text/graphics stages.
package vga_timing_pkg;

   localparam int CNT_W = 10;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t H_DISPLAY = 10'd640;
   localparam cnt_t H_FRONT   = 10'd16;
   localparam cnt_t H_SYNC    = 10'd96;
   localparam cnt_t H_BACK    = 10'd48;
   localparam cnt_t H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

   localparam cnt_t V_DISPLAY = 10'd480;
   localparam cnt_t V_FRONT   = 10'd10;
   localparam cnt_t V_SYNC    = 10'd2;
   localparam cnt_t V_BACK    = 10'd33;
   localparam cnt_t V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   // Both syncs are active low for this mode.
   localparam logic SYNC_ACTIVE = 1'b0;

   localparam cnt_t H_MAX        = H_TOTAL - 10'd1;
   localparam cnt_t V_MAX        = V_TOTAL - 10'd1;
   localparam cnt_t H_SYNC_START = H_DISPLAY + H_FRONT;
   localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
   localparam cnt_t V_SYNC_START = V_DISPLAY + V_FRONT;
   localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE, video_on: 1'b0};

   function automatic sync_t sync_decode(input cnt_t px, input cnt_t py);
      sync_t s;
      s.hsync    = (px >= H_SYNC_START && px <= H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      s.vsync    = (py >= V_SYNC_START && py <= V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      s.video_on = (px < H_DISPLAY) && (py < V_DISPLAY);
      return s;
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running clk divider; p_tick marks the last clk cycle of each pixel.
module pixel_tick_div #(
   parameter int DIV_LOG2 = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic p_tick
);

   generate
      if (DIV_LOG2 == 0) begin : g_no_div
         // Every clk is a pixel; still held low while in reset.
         assign p_tick = rst_n;
      end else begin : g_div
         logic [DIV_LOG2-1:0] div_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + DIV_LOG2'(1);
            end
         end

         assign p_tick = &div_cnt;
      end
   endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters with registered sync/blank outputs aligned to (x,y)
// and a one-clk frame_start pulse on the wrap to (0,0).
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int DIV_LOG2 = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       p_tick,
   output logic       frame_start
);

   cnt_t  x_next;
   cnt_t  y_next;
   sync_t sync_next;
   logic  line_end;
   logic  frame_end;

   pixel_tick_div #(
      .DIV_LOG2(DIV_LOG2)
   ) u_pixel_tick_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .p_tick (p_tick)
   );

   // Sync outputs are decoded from the next position so they land on the
   // same edge as the counters and never lag (x,y).
   always_comb begin
      line_end  = (x == H_MAX);
      frame_end = line_end && (y == V_MAX);
      x_next    = line_end ? '0 : x + 10'd1;
      y_next    = y;
      if (line_end) begin
         y_next = (y == V_MAX) ? '0 : y + 10'd1;
      end
      sync_next = sync_decode(x_next, y_next);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x           <= '0;
         y           <= '0;
         hsync       <= SYNC_IDLE.hsync;
         vsync       <= SYNC_IDLE.vsync;
         video_on    <= SYNC_IDLE.video_on;
         frame_start <= 1'b0;
      end else begin
         frame_start <= p_tick && frame_end;
         if (p_tick) begin
            x        <= x_next;
            y        <= y_next;
            hsync    <= sync_next.hsync;
            vsync    <= sync_next.vsync;
            video_on <= sync_next.video_on;
         end
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: reference model tracks a linear pixel index and
// clk phase, and every clk all outputs are compared against it.
module tb_vga_sync_gen;

   localparam int DIV_LOG2  = 2;
   localparam int DIV       = 1 << DIV_LOG2;
   localparam int LINE_PIX  = 800;
   localparam int FRAME_PIX = 800 * 525;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [9:0] x;
   logic [9:0] y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       p_tick;
   logic       frame_start;

   always #5 clk = ~clk;

   vga_sync_gen #(
      .DIV_LOG2(DIV_LOG2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .video_on    (video_on),
      .hsync       (hsync),
      .vsync       (vsync),
      .p_tick      (p_tick),
      .frame_start (frame_start)
   );

   int chk_cnt = 0;
   int err_cnt = 0;

   // Model: m_mode 0 = reset look (blanked, syncs idle), 1 = normal,
   // 2 = just relocated, sync outputs not yet refreshed.
   int   m_phase = 0;
   int   m_pix   = 0;
   int   m_mode  = 0;
   logic m_fs    = 1'b0;

   logic [9:0] jump_x;
   logic [9:0] jump_y;

   bit         prev_ok    = 0;
   logic       last_hs    = 1'b1;
   logic [9:0] last_y     = '0;
   bit         hs_track   = 0;
   int         hs_len     = 0;
   bit         line_track = 0;
   int         line_len   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0d exp=%0d t=%0t pix=%0d", tag, got, exp, $time, m_pix);
      end
   endtask

   task automatic check_all();
      int ex;
      int ey;
      ex = m_pix % LINE_PIX;
      ey = m_pix / LINE_PIX;
      check_eq("x", x, ex);
      check_eq("y", y, ey);
      check_eq("p_tick", p_tick, (rst_n && m_phase == DIV - 1) ? 1 : 0);
      check_eq("frame_start", frame_start, m_fs);
      if (m_mode == 0) begin
         check_eq("video_on_blank", video_on, 0);
         check_eq("hsync_idle", hsync, 1);
         check_eq("vsync_idle", vsync, 1);
      end else if (m_mode == 1) begin
         check_eq("video_on", video_on, (ex < 640 && ey < 480) ? 1 : 0);
         check_eq("hsync", hsync, (ex >= 656 && ex <= 751) ? 0 : 1);
         check_eq("vsync", vsync, (ey >= 490 && ey <= 491) ? 0 : 1);
      end
   endtask

   task automatic measure();
      if (m_mode == 1 && rst_n) begin
         if (prev_ok) begin
            if (last_hs && !hsync) begin
               hs_len   = 1;
               hs_track = 1;
            end else if (!hsync && hs_track) begin
               hs_len++;
            end else if (hsync && !last_hs && hs_track) begin
               check_eq("hsync_low_clks", hs_len, 384);
               hs_track = 0;
            end
            if (y != last_y) begin
               check_eq("x_at_line_step", x, 0);
               if (line_track) check_eq("line_clks", line_len, 3200);
               line_len   = 1;
               line_track = 1;
            end else begin
               line_len++;
            end
         end
         prev_ok = 1;
      end else begin
         prev_ok    = 0;
         hs_track   = 0;
         line_track = 0;
      end
      last_hs = hsync;
      last_y  = y;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) begin
         m_fs = 1'b0;
         if (m_phase == DIV - 1) begin
            m_pix  = (m_pix + 1) % FRAME_PIX;
            m_fs   = (m_pix == 0);
            m_mode = 1;
         end
         m_phase = (m_phase + 1) % DIV;
      end
      @(negedge clk);
      check_all();
      measure();
   endtask

   // Asserted between edges; outputs must settle with no clk edge involved.
   task automatic async_reset(input int hold);
      rst_n   = 1'b0;
      m_phase = 0;
      m_pix   = 0;
      m_mode  = 0;
      m_fs    = 1'b0;
      #1;
      check_all();
      measure();
      repeat (hold) step();
      rst_n = 1'b1;
   endtask

   task automatic jump_to(input int jx, input int jy);
      for (int i = 0; i < DIV && m_phase != 0; i++) step();
      jump_x = 10'(jx);
      jump_y = 10'(jy);
      force dut.x = jump_x;
      force dut.y = jump_y;
      #1;
      release dut.x;
      release dut.y;
      m_pix   = jy * LINE_PIX + jx;
      m_mode  = 2;
      prev_ok = 0;
      hs_track   = 0;
      line_track = 0;
   endtask

   task automatic wait_frame_start(input int budget);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (m_fs) seen = 1;
      end
      if (!seen) check_eq("frame_start_timeout", 0, 1);
   endtask

   initial begin
      #2;
      async_reset($urandom_range(2, 6));

      // Reset release, first lines: tick cadence, hsync width, line length.
      repeat (7000) step();

      // Bottom of the visible area.
      jump_to(790, 478);
      repeat (9700) step();

      // Vertical sync region.
      jump_to(790, 488);
      repeat (19300) step();

      // Frame wrap, then a reset landing while frame_start is high.
      jump_to(790, 523);
      wait_frame_start(8000);
      #2;
      async_reset(3);
      repeat (40) step();

      // Mid-frame reset near (300,200).
      jump_to(300, 200);
      repeat ($urandom_range(1, 40)) step();
      #2;
      async_reset($urandom_range(1, 4));
      repeat (40) step();

      // Random raster positions.
      for (int k = 0; k < 3; k++) begin
         jump_to($urandom_range(0, 799), $urandom_range(0, 524));
         repeat (800) step();
      end

      $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter: DIV_LOG2, default 2, log2 of clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: x  output  10  current horizontal pixel counter, 0..799, consumed by text/graphics stages.
REQ-005 Port: y  output  10  current vertical line counter, 0..524.
REQ-006 Port: video_on  output  1  high when (x,y) is inside the 640x480 visible area.
REQ-007 Port: hsync  output  1  horizontal sync, active low.
REQ-008 Port: vsync  output  1  vertical sync, active low.
REQ-009 Port: p_tick  output  1  one-clk pulse marking the last clk cycle of each pixel period.
REQ-010 Port: frame_start  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-011 Divider: DIV_LOG2-bit counter increments every clk and wraps; p_tick SHALL be high exactly when the divider is all-ones (every 4th clk at default).
REQ-012 Horizontal timing SHALL be: 640 display, 16 front porch, 96 sync, 48 back porch, 800 total.
REQ-013 Vertical timing SHALL be: 480 display, 10 front porch, 2 sync, 33 back porch, 525 total.
REQ-014 On a clk edge with p_tick high, x SHALL increment by 1; x=799 SHALL wrap to 0.
REQ-015 y SHALL increment only on the edge where x wraps 799->0; y=524 with x=799 SHALL wrap to (0,0).
REQ-016 x and y SHALL hold their values on all edges where p_tick is low.
REQ-017 hsync, vsync and video_on SHALL be registered, updated on the same edge as x/y, from the next counter values, so they are always consistent with the current (x,y); no extra latency.
REQ-018 hsync SHALL be 0 for x in 656..751 inclusive, else 1.
REQ-019 vsync SHALL be 0 for y in 490..491 inclusive, else 1.
REQ-020 video_on SHALL be 1 for x<640 and y<480, else 0.
REQ-021 frame_start SHALL be 1 for exactly the one clk cycle following the edge that wraps (799,524)->(0,0); otherwise 0.
REQ-022 Counter arithmetic SHALL be unsigned 10-bit; no value outside stated ranges shall ever appear on x or y.

Reset
REQ-023 While rst_n=0: divider=0, x=0, y=0, hsync=1, vsync=1, video_on=0, frame_start=0, p_tick=0.
REQ-024 After rst_n deasserts, first p_tick SHALL occur on the 4th clk edge (default); first counter update to (1,0) on that edge.
REQ-025 Pixel (0,0) of the first frame after reset is blanked (video_on=0); from the second pixel onward timing is normal.
REQ-026 Reset asserted mid-frame SHALL immediately (asynchronously) force REQ-023 values; no frame_start pulse on reset.

Structure
REQ-027 Timing constants (H/V display, porch, sync, total widths, sync polarity) SHALL live in shared package vga_timing_pkg, reused by text and graphics stages.
REQ-028 One sub-module: pixel_tick_div (divider + p_tick decode); counters and sync decode stay in vga_sync_gen.

Verification
REQ-029 Reset release, run 12 clk -> p_tick high on cycles 4, 8, 12 only; x=3 after cycle 12, y=0.
REQ-030 Run to x=655->656 -> hsync falls on that edge; x=752 -> hsync rises; 96 pixels low (384 clk).
REQ-031 Run one full line -> x wraps 799->0 and y 0->1 on the same edge; line length 3200 clk.
REQ-032 Run full frame -> vsync low exactly for y=490,491; frame_start single pulse after (799,524)->(0,0); frame = 1,680,000 clk.
REQ-033 Check video_on at (639,0)=1, (640,0)=0, (0,479)=1, (0,480)=0.
REQ-034 Assert rst_n=0 at (300,200) between clk edges -> outputs reach REQ-023 values without a clk edge; no frame_start.
